// File: rtl/uart_pkg.sv
// Shared constants and sizing helpers for the UART receive FIFO slice.
// UART_RX_FIFO_BREAK_EN widens each entry by one bit to carry the BREAK flag.
package uart_pkg;

    localparam int DEF_PAYLOAD_BITS = 8;

`ifdef UART_RX_FIFO_BREAK_EN
    localparam bit BREAK_EN = 1'b1;
`else
    localparam bit BREAK_EN = 1'b0;
`endif

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // The break flag sits directly above the payload bits in a stored entry.
    function automatic int break_bit_pos(input int payload_bits);
        return payload_bits;
    endfunction

    function automatic int entry_w(input int payload_bits);
        return payload_bits + (BREAK_EN ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receiver into the FIFO and from the FIFO to its consumer.
// out_break exists only when UART_RX_FIFO_BREAK_EN is defined.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
);
    logic                    in_valid;
    logic [PAYLOAD_BITS-1:0] in_data;
    logic                    in_break;
    logic                    out_valid;
    logic                    out_ready;
    logic [PAYLOAD_BITS-1:0] out_data;
`ifdef UART_RX_FIFO_BREAK_EN
    logic                    out_break;
`endif

    // FIFO side: sinks the receiver strobe, sources the consumer stream.
    modport slave (
        input  in_valid, in_data, in_break, out_ready,
`ifdef UART_RX_FIFO_BREAK_EN
        output out_break,
`endif
        output out_valid, out_data
    );

    // Environment side: receiver plus consumer.
    modport master (
        output in_valid, in_data, in_break, out_ready,
`ifdef UART_RX_FIFO_BREAK_EN
        input  out_break,
`endif
        input  out_valid, out_data
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module uart_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and count,
    // so resetting storage would only cost flops and reset fan-out.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: circular buffer, fill status, sticky overflow.
// Define UART_RX_FIFO_BREAK_EN to buffer BREAK frames and expose out_break.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int PAYLOAD_BITS      = DEF_PAYLOAD_BITS,
    parameter  int DEPTH             = 16,
    parameter  int ALMOST_FULL_LEVEL = 12,
    localparam int PTR_W             = ptr_w(DEPTH),
    localparam int CNT_W             = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    uart_rx_fifo_if.slave    bus,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    input  logic             ovf_clear
);
    localparam int ENTRY_W = entry_w(PAYLOAD_BITS);

    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [ENTRY_W-1:0] wdata, rdata;
    logic               accept, push, pop, drop, out_valid;

`ifdef UART_RX_FIFO_BREAK_EN
    localparam int BRK_POS = break_bit_pos(PAYLOAD_BITS);
    assign accept        = bus.in_valid;
    assign wdata         = {bus.in_break, bus.in_data};
    assign bus.out_break = out_valid & rdata[BRK_POS];
`else
    // BREAK frames are swallowed here: they neither push nor count as a drop.
    assign accept = bus.in_valid & ~bus.in_break;
    assign wdata  = bus.in_data;
`endif

    assign out_valid     = (count != '0);
    assign full          = (count == CNT_W'(DEPTH));
    assign almost_full   = (count >= CNT_W'(ALMOST_FULL_LEVEL));
    assign pop           = out_valid & bus.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push          = accept & (~full | pop);
    assign drop          = accept & full & ~pop;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? rdata[PAYLOAD_BITS-1:0] : '0;

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)           overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] count;
    logic       full, almost_full, overflow, ovf_clear;

    uart_rx_fifo_if #(.PAYLOAD_BITS(8)) bus ();

    uart_rx_fifo #(
        .PAYLOAD_BITS      (8),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_clear   (ovf_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {break, data} entries plus the sticky flag.
    logic [8:0] q[$];
    bit         m_ovf;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         b;
        bit         r;
        bit         c;
        int         e_cnt;
        bit         e_val;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        int n;
        n = q.size();
        check("count", 32'(count), 32'(n));
        check("out_valid", 32'(bus.out_valid), 32'(n != 0));
        check("out_data", 32'(bus.out_data), (n != 0) ? 32'(q[0][7:0]) : 32'd0);
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'(n >= AFL));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_BREAK_EN
        check("out_break", 32'(bus.out_break), (n != 0) ? 32'(q[0][8]) : 32'd0);
`endif
    endtask

    // Drive one cycle, advance the model, then compare just after the edge.
    task automatic cycle(input bit rst, input bit v, input logic [7:0] d,
                         input bit b, input bit r, input bit c);
        bit pop, acc, dropped;
        resetn       = ~rst;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_break = b;
        bus.out_ready = r;
        ovf_clear    = c;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            pop     = r && (q.size() != 0);
            acc     = v && (BREAK_EN || !b);
            dropped = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (q.size() < DEPTH) q.push_back({b, d});
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (c)  m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_break  = 1'b0;
        bus.out_ready = 1'b0;
        ovf_clear     = 1'b0;
        resetn        = 1'b0;

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'd0);

        // Basic order, empty-ready, break handling, break without valid.
        tbl.push_back('{1, 8'h41, 0, 0, 0, 1, 1, 8'h41});
        tbl.push_back('{1, 8'h42, 0, 0, 0, 2, 1, 8'h41});
        tbl.push_back('{1, 8'h43, 0, 0, 0, 3, 1, 8'h41});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 2, 1, 8'h42});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 1, 1, 8'h43});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 0, 8'h00});
        tbl.push_back('{0, 8'h00, 0, 1, 0, 0, 0, 8'h00});
`ifdef UART_RX_FIFO_BREAK_EN
        tbl.push_back('{1, 8'h00, 1, 0, 0, 1, 1, 8'h00});
`else
        tbl.push_back('{1, 8'h00, 1, 0, 0, 0, 0, 8'h00});
`endif
        tbl.push_back('{0, 8'h5A, 1, 1, 0, 0, 0, 8'h00});
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].b, tbl[i].r, tbl[i].c);
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_val));
            check($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
        end

        // Fill, almost_full threshold, full simultaneous push/pop, drop, clear race.
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(i));
            if (i == AFL - 2) check("af_below", 32'(almost_full), 32'd0);
            if (i == AFL - 1) check("af_at", 32'(almost_full), 32'd1);
        end
        check("fill_full", 32'(full), 32'd1);
        cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        check("simul_count", 32'(count), 32'd16);
        check("simul_ovf", 32'(overflow), 32'd0);
        push(8'hAA);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_count", 32'(count), 32'd16);
        cycle(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
        check("race_ovf", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clear_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_data", 32'(bus.out_data), (i < DEPTH - 1) ? 32'(i + 1) : 32'h55);
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        // Wrap-around with occupancy held at 3.
        for (int i = 0; i < 3; i++) push(8'(i));
        for (int i = 0; i < 40; i++) begin
            check("wrap_data", 32'(bus.out_data), 32'(i));
            cycle(1'b0, 1'b1, 8'(i + 3), 1'b0, 1'b1, 1'b0);
            check("wrap_count", 32'(count), 32'd3);
        end
        for (int i = 40; i < 43; i++) begin
            check("wrap_tail", 32'(bus.out_data), 32'(i));
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end

        // Mid-operation reset with count=5 and overflow set.
        for (int i = 0; i < DEPTH + 1; i++) push(8'(8'hC0 + i));
        for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Randomized traffic: slow consumer first to exercise full/overflow, then balanced.
        for (int i = 0; i < 3000; i++) begin
            bit rst, v, b, r, c;
            rst = ($urandom_range(0, 499) == 0);
            v   = ($urandom_range(0, 1) == 1);
            b   = ($urandom_range(0, 9) == 0);
            r   = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            c   = ($urandom_range(0, 19) == 0);
            cycle(rst, v, 8'($urandom), b, r, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each one-cycle received-byte strobe (valid plus data plus break flag) into a circular FIFO. It presents the buffered bytes to the consumer, e.g. the echo/command logic, via a valid/ready handshake. It also provides fill-level status and a sticky overflow flag, so bytes are not lost when the consumer stalls for several character times.

Parameters:
- PAYLOAD_BITS, 8: data bits per byte; must match the receiver.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- ALMOST_FULL_LEVEL, 12: almost_full asserts when count >= this value; range 1..DEPTH.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  one-cycle strobe: received byte available (from receiver valid)
- in_data  in  PAYLOAD_BITS  received byte
- in_break  in  1  received frame was a BREAK (all-zero data); qualified by in_valid
- out_valid  out  1  FIFO non-empty; head byte on out_data
- out_ready  in  1  consumer accepts head byte when out_valid && out_ready
- out_data  out  PAYLOAD_BITS  head byte
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- almost_full  out  1  count >= ALMOST_FULL_LEVEL
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- ovf_clear  in  1  synchronous clear of overflow

Behaviour:
- Reset: clk is the clock; resetn is the reset, synchronous and active-low. While resetn=0: write/read pointers=0, count=0, overflow=0.
  - Resulting outputs: out_valid=0, full=0, almost_full=0 (ALMOST_FULL_LEVEL>=1), out_data=0.
  - Reset mid-operation discards all contents.
- Push condition: push = in_valid && !in_break && (!full || pop). Break frames are never written unless UART_RX_FIFO_BREAK_EN is defined.
- Pop condition: pop = out_valid && out_ready.
- Storage: written at mem[wr_ptr] on push; wr_ptr increments modulo DEPTH on push, rd_ptr modulo DEPTH on pop.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Count update: count += push - pop each cycle. Simultaneous push and pop leaves count unchanged, including when full (push is accepted because a slot frees the same cycle) and when count==1.
- Latency: a byte pushed at edge N is visible at edge N+1, i.e. out_valid=1 and out_data=byte in the cycle after the in_valid cycle.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] (asynchronous read), forced to 0 when empty.
- Ordering: strict FIFO order.
- Empty with in_valid: no bypass; the byte appears 1 cycle later.
- Overflow: in_valid && !in_break && full && !pop drops the byte and sets overflow=1 at the next edge.
  - ovf_clear=1 clears overflow at the next edge.
  - A drop and ovf_clear in the same cycle leave overflow=1 (set wins).
- Unused-input rules: out_ready while empty has no effect. in_break without in_valid has no effect.
- Status outputs: full, almost_full and count are derived from registered count, not from next-state values.

Optional Feature:
Macro UART_RX_FIFO_BREAK_EN.
- Defined:
  - Each entry stores an extra break bit, and BREAK frames are pushed like data.
  - Extra port out_break (out, 1) = break bit of the head entry; 0 when empty.
  - Overflow rules apply equally to break entries.
- Undefined:
  - BREAK frames are discarded silently: no push, no overflow.
  - No out_break port; entry width is PAYLOAD_BITS.

Decomposition:
- Package uart_pkg holds:
  - default PAYLOAD_BITS (8);
  - the break-flag bit position constant;
  - a pointer-width helper constant/function, $clog2(DEPTH).
- Sub-module uart_rx_fifo_mem: DEPTH x entry-width register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count and flag logic stays in uart_rx_fifo.

Test Plan:
- Basic order: push 0x41, 0x42, 0x43 on separate cycles, out_ready=0 -> count=3, out_data=0x41. Then out_ready=1 for 3 cycles -> pops 0x41, 0x42, 0x43 in order, then out_valid=0, count=0.
- Fill and overflow: DEPTH=16, push 0x00..0x0F -> full=1, almost_full=1 (from count=12). Push 0xAA -> dropped, overflow=1, count=16. Drain -> 0x00..0x0F; 0xAA never appears.
- Full simultaneous: with count=16, in_valid=1 with data 0x55 and out_ready=1 in the same cycle -> count stays 16, overflow stays 0, 0x55 emerges as the 16th byte after the head.
- Wrap-around: repeat 40 push/pop pairs of incrementing bytes with occupancy held at 3 -> output sequence exactly matches input; pointers wrap twice; count never exceeds 4.
- Overflow clear race: overflow=1; assert ovf_clear and an overflowing push in the same cycle -> overflow stays 1. A later ovf_clear alone -> overflow=0.
- Break and reset:
  - Macro undefined: in_valid=1, in_break=1, in_data=0x00 -> no push.
  - Macro defined: entry pushed with out_break=1.
  - resetn=0 for one cycle with count=5 -> count=0, out_valid=0, overflow=0 next cycle.
